seq_divider: RTL and testbench

Iterative unsigned integer divider: the inverse operation of the team's combinational Wallace-tree multiplier, used wherever a quotient/remainder pair is needed and a multi-cycle latency is acceptable. It implements a radix-2 restoring algorithm producing one quotient bit per clock. A start/busy/done handshake connects it to a controller. Divide-by-zero is detected and flagged without running the iteration loop.

---
 rtl/seq_divider_if.sv | 17 +
 rtl/seq_divider.sv | 102 ++++++++++
 tb/tb_seq_divider.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle for seq_divider.
// The controller uses the master modport and the divider uses the slave modport.
interface seq_divider_if #(
    parameter int W = 32
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;

    modport master (output start, a, b, input busy, done, q, r, dz);
    modport slave  (input start, a, b, output busy, done, q, r, dz);
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider that produces one quotient bit per clock.
// A zero divisor skips the iteration loop and is reported through dz.
module seq_divider #(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [W-1:0]  qreg;
    logic [W-1:0]  divisor;
    logic [W:0]    rem;
    logic [CW-1:0] cnt;

    logic          busy_r;
    logic          done_r;
    logic [W-1:0]  q_r;
    logic [W-1:0]  r_r;
    logic          dz_r;

    logic [W:0]    rem_sh;
    logic [W:0]    trial;
    logic [W:0]    rem_next;
    logic [W-1:0]  qreg_next;

    // The partial remainder stays below the divisor, so bit W is free to act as the trial borrow.
    always_comb begin
        rem_sh    = {rem[W-1:0], qreg[W-1]};
        trial     = rem_sh - {1'b0, divisor};
        rem_next  = trial[W] ? rem_sh : trial;
        qreg_next = {qreg[W-2:0], ~trial[W]};
    end

    // NOTE: every state and output register uses non-blocking assignments, so each read in
    // this block sees the value from the previous edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            qreg    <= '0;
            divisor <= '0;
            rem     <= '0;
            cnt     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            q_r     <= '0;
            r_r     <= '0;
            dz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                // DONE accepts a new request exactly like IDLE, which allows back-to-back operation.
                IDLE, DONE: begin
                    state <= IDLE;
                    if (bus.start) begin
                        if (bus.b == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            q_r    <= '1;
                            r_r    <= bus.a;
                            dz_r   <= 1'b1;
                        end else begin
                            state   <= CALC;
                            busy_r  <= 1'b1;
                            qreg    <= bus.a;
                            divisor <= bus.b;
                            rem     <= '0;
                            cnt     <= CW'(W);
                        end
                    end
                end
                CALC: begin
                    rem  <= rem_next;
                    qreg <= qreg_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        q_r    <= qreg_next;
                        r_r    <= rem_next[W-1:0];
                        dz_r   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.q    = q_r;
    assign bus.r    = r_r;
    assign bus.dz   = dz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed handshake cases followed by random
// operands, checked against plain a/b and a%b arithmetic.
module tb_seq_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    seq_divider_if #(.W(W)) bus ();

    seq_divider #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model: the division written as plain arithmetic.
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] av, input logic [W-1:0] bv);
        return (bv == '0) ? '1 : av / bv;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] av, input logic [W-1:0] bv);
        return (bv == '0) ? av : av % bv;
    endfunction

    // Issue one request, wait for done and check the latency, the busy window and the results.
    task automatic run_div(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        int lat;
        int busy_cnt;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        step();
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat      = 1;
        busy_cnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            step();
            lat++;
        end
        check({tag, " latency"}, lat, (bv == '0) ? 1 : W + 1);
        check({tag, " busy_cycles"}, busy_cnt, (bv == '0) ? 0 : W);
        check({tag, " busy_at_done"}, bus.busy, 1'b0);
        check({tag, " q"}, bus.q, ref_q(av, bv));
        check({tag, " r"}, bus.r, ref_r(av, bv));
        check({tag, " dz"}, bus.dz, (bv == '0));
        step();
        check({tag, " done_pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        int n;
        int done_cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset q", bus.q, '0);
        check("reset r", bus.r, '0);
        check("reset dz", bus.dz, 1'b0);

        run_div("100/7", 32'd100, 32'd7);
        run_div("max/1", 32'hFFFF_FFFF, 32'd1);
        run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_div("3/10", 32'd3, 32'd10);
        run_div("5/0", 32'd5, 32'd0);
        run_div("after_dz", 32'd1000, 32'd33);

        // A start raised while busy is ignored; held through DONE it is accepted there.
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd2;
        n = 0;
        while (!bus.done && n < 40) begin
            step();
            n++;
        end
        check("ignore first_done", bus.done, 1'b1);
        check("ignore q", bus.q, 32'd14);
        check("ignore r", bus.r, 32'd2);
        step();
        bus.start = 1'b0;
        check("b2b busy", bus.busy, 1'b1);
        n = 1;
        while (!bus.done && n < 40) begin
            step();
            n++;
        end
        check("b2b latency", n, W + 1);
        check("b2b q", bus.q, 32'd4);
        check("b2b r", bus.r, 32'd1);
        step();

        // Reset in the middle of a division aborts it without a done pulse.
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        step();
        bus.start = 1'b0;
        repeat (14) step();
        check("pre_abort busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort busy", bus.busy, 1'b0);
        check("abort done", bus.done, 1'b0);
        check("abort q", bus.q, '0);
        check("abort r", bus.r, '0);
        step();
        rst = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            step();
            if (bus.done) done_cnt++;
        end
        check("abort no_done", done_cnt, 0);
        check("abort idle busy", bus.busy, 1'b0);

        // Random operands, weighted towards zero, small and a<b divisors.
        for (int i = 0; i < 1500; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = ra + $urandom_range(1, 1000);
                3:       begin ra = $urandom_range(0, 255); rb = $urandom_range(1, 255); end
                4:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_div("rand", ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
